// File: rtl/trace_pkg.sv
// ----------------------------------------------------------------------------
// trace_pkg
// Shared types for the commit trace path.
//   trace_rec_t  : one retired-instruction record as seen by the trace sink
//   TRACE_REC_W  : packed width of trace_rec_t
//   count_valid  : number of asserted strobes in a 2-port commit group
// No ports (package).
// ----------------------------------------------------------------------------
package trace_pkg;

    localparam int VLEN = 64;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [63:0]     wdata;
        logic            we_gpr;
        logic            we_fpr;
        logic [1:0]      priv;
        logic            is_exc;
        logic [63:0]     cause;
        logic [63:0]     cycle;
    } trace_rec_t;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

    // Population count of a two-bit commit strobe vector (0..2).
    function automatic logic [1:0] count_valid(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/trace_commit_sequencer_if.sv
// ----------------------------------------------------------------------------
// trace_commit_sequencer_if
// Bundles the commit-side inputs and the trace-stream handshake.
//   commit_valid_i : per-port retire strobe
//   commit_rec_i   : per-port retire record
//   out_valid_o    : head record available
//   out_ready_i    : sink accepts head
//   out_rec_o      : head record
// Modports:
//   slave  : the sequencer (consumes commits, drives the stream)
//   master : the environment (drives commits, consumes the stream)
// ----------------------------------------------------------------------------
interface trace_commit_sequencer_if;
    import trace_pkg::*;

    logic [1:0]       commit_valid_i;
    trace_rec_t [1:0] commit_rec_i;
    logic             out_valid_o;
    logic             out_ready_i;
    trace_rec_t       out_rec_o;

    modport slave (
        input  commit_valid_i,
        input  commit_rec_i,
        input  out_ready_i,
        output out_valid_o,
        output out_rec_o
    );

    modport master (
        output commit_valid_i,
        output commit_rec_i,
        output out_ready_i,
        input  out_valid_o,
        input  out_rec_o
    );

endinterface

// File: rtl/trace_dual_push_fifo.sv
// ----------------------------------------------------------------------------
// trace_dual_push_fifo
// Record storage with two write slots per cycle and one read port.
// Full/empty are derived from an explicit occupancy count.
//   clk_i      : clock
//   rst_i      : synchronous reset, active-high
//   clear_i    : synchronous flush (same effect as reset on pointers/count)
//   n_wr_i     : number of records to write this cycle (0..2)
//   wr_data0_i : record for the first free slot
//   wr_data1_i : record for the second free slot (used when n_wr_i == 2)
//   pop_i      : consume the head record (ignored when empty)
//   rd_data_o  : head record, '0 when empty
//   count_o    : occupancy 0..DEPTH
// The caller guarantees n_wr_i never exceeds the free space.
// ----------------------------------------------------------------------------
module trace_dual_push_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic [1:0]               n_wr_i,
    input  trace_rec_t               wr_data0_i,
    input  trace_rec_t               wr_data1_i,
    input  logic                     pop_i,
    output trace_rec_t               rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    trace_rec_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W:0]   count_q;
    logic [1:0]       n_wr;
    logic             do_pop;

    // Writes and pops are discarded while reset or flush is active.
    assign n_wr      = (rst_i || clear_i) ? 2'd0 : n_wr_i;
    assign do_pop    = pop_i && (count_q != '0) && !clear_i;
    assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

    // Storage is not reset; only entries between rd and wr pointers are live.
    always_ff @(posedge clk_i) begin
        if (n_wr != 2'd0) begin
            mem[wr_ptr_q] <= wr_data0_i;
        end
        if (n_wr == 2'd2) begin
            mem[wr_ptr_p1] <= wr_data1_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_wr);
            rd_ptr_q <= rd_ptr_q + PTR_W'(do_pop);
            count_q  <= count_q + (PTR_W+1)'(n_wr) - (PTR_W+1)'(do_pop);
        end
    end

    // Head is gated to zero when empty so the idle stream shows '0 rather
    // than stale storage; it depends on registered state only.
    assign rd_data_o = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign count_o   = count_q;

endmodule

// File: rtl/trace_commit_sequencer.sv
// ----------------------------------------------------------------------------
// trace_commit_sequencer
// Serialises retired-instruction records from two commit ports, oldest first,
// into a single valid/ready trace stream. Commit never stalls: records that do
// not fit are dropped (youngest first), counted and flagged.
//   clk_i       : clock
//   rst_i       : synchronous reset, active-high
//   trace_en_i  : 1 = capture commits, 0 = ignore commits but keep draining
//   clear_i     : flush FIFO, zero drop counter, clear overflow flag
//   bus         : trace_commit_sequencer_if.slave (commits in, stream out)
//   level_o     : FIFO occupancy
//   overflow_o  : sticky, at least one record dropped
//   drop_cnt_o  : saturating count of dropped records
// Build option TRACE_CYCLE_STAMP_EN: adds a 64-bit free-running cycle counter
// whose value is written into rec.cycle of every accepted record; otherwise
// rec.cycle is driven as zero.
// ----------------------------------------------------------------------------
module trace_commit_sequencer
    import trace_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 32,
    parameter int NR_COMMIT = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     trace_en_i,
    input  logic                     clear_i,
    trace_commit_sequencer_if.slave  bus,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    if (NR_COMMIT != 2) begin : g_bad_nr_commit
        $error("trace_commit_sequencer: NR_COMMIT must be 2");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("trace_commit_sequencer: DEPTH must be a power of two >= 4");
    end

    logic [LVL_W-1:0] count;
    logic [LVL_W-1:0] free;
    logic [1:0]       n_req;
    logic [1:0]       n_acc;
    logic [1:0]       n_drop;
    logic             pop;
    logic [63:0]      stamp;
    trace_rec_t       slot0;
    trace_rec_t       slot1;
    trace_rec_t       head_rec;
    logic             overflow_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W:0]   sat_sum;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [63:0] cycle_q;

    // Free-running from reset; the CSR clear deliberately leaves it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    assign stamp = cycle_q;
`else
    assign stamp = '0;
`endif

    // Free space comes from the registered count only: a same-cycle pop does
    // not make room, which keeps the accept path off the sink's ready.
    assign free = LVL_W'(DEPTH) - count;

    always_comb begin
        n_req = trace_en_i ? count_valid(bus.commit_valid_i) : 2'd0;
        if (LVL_W'(n_req) > free) begin
            n_acc = free[1:0];
        end else begin
            n_acc = n_req;
        end
        n_drop = n_req - n_acc;
    end

    // Compact the valid ports into consecutive slots. When only port1 is
    // valid it lands in the first slot; when both are valid and only one fits,
    // the write count of 1 keeps port0 and drops port1 (youngest).
    always_comb begin
        slot0       = bus.commit_valid_i[0] ? bus.commit_rec_i[0] : bus.commit_rec_i[1];
        slot1       = bus.commit_rec_i[1];
        slot0.cycle = stamp;
        slot1.cycle = stamp;
    end

    assign pop = (count != '0) && bus.out_ready_i;

    trace_dual_push_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .n_wr_i     (n_acc),
        .wr_data0_i (slot0),
        .wr_data1_i (slot1),
        .pop_i      (pop),
        .rd_data_o  (head_rec),
        .count_o    (count)
    );

    assign sat_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);

    // Drop accounting; clear takes priority and discards same-cycle drops.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (n_drop != 2'd0) begin
            overflow_q <= 1'b1;
            drop_cnt_q <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
        end
    end

    assign bus.out_valid_o = (count != '0);
    assign bus.out_rec_o   = head_rec;
    assign level_o         = count;
    assign overflow_o      = overflow_q;
    assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_trace_commit_sequencer.sv
// ----------------------------------------------------------------------------
// tb_trace_commit_sequencer
// Drives trace_commit_sequencer (DEPTH=4) with directed scenarios and random
// traffic, comparing against a queue-based model of the record stream. A
// second instance with a 2-bit drop counter exercises counter saturation.
// ----------------------------------------------------------------------------
module tb_trace_commit_sequencer;
    import trace_pkg::*;

    localparam int DEPTH_TB = 4;

    logic        clk;
    logic        rst;
    logic        trace_en;
    logic        clear;
    logic [2:0]  level;
    logic        overflow;
    logic [31:0] drop_cnt;

    logic        sat_en;
    logic        sat_clear;
    logic [2:0]  sat_level;
    logic        sat_ovf;
    logic [1:0]  sat_drop;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    trace_rec_t      mq[$];
    logic [31:0]     m_drops;
    logic            m_ovf;
    longint unsigned m_cycle;

    trace_commit_sequencer_if bus ();
    trace_commit_sequencer_if bus_sat ();

    trace_commit_sequencer #(
        .DEPTH     (DEPTH_TB),
        .CNT_W     (32),
        .NR_COMMIT (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .trace_en_i (trace_en),
        .clear_i    (clear),
        .bus        (bus),
        .level_o    (level),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt)
    );

    trace_commit_sequencer #(
        .DEPTH     (DEPTH_TB),
        .CNT_W     (2),
        .NR_COMMIT (2)
    ) dut_sat (
        .clk_i      (clk),
        .rst_i      (rst),
        .trace_en_i (sat_en),
        .clear_i    (sat_clear),
        .bus        (bus_sat),
        .level_o    (sat_level),
        .overflow_o (sat_ovf),
        .drop_cnt_o (sat_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic trace_rec_t mk_rec(input logic [63:0] pc);
        trace_rec_t r;
        r.pc     = pc;
        r.instr  = $urandom;
        r.rd     = 5'($urandom);
        r.wdata  = {$urandom, $urandom};
        r.we_gpr = 1'($urandom);
        r.we_fpr = 1'($urandom);
        r.priv   = 2'($urandom);
        r.is_exc = 1'($urandom);
        r.cause  = {$urandom, $urandom};
        r.cycle  = {$urandom, $urandom};
        return r;
    endfunction

    // One clock of the behavioural stream model.
    function automatic void model_step(input logic r, input logic c, input logic en,
                                       input logic [1:0] v, input trace_rec_t r0,
                                       input trace_rec_t r1, input logic rdy);
        trace_rec_t      reqs[$];
        trace_rec_t      rec;
        longint unsigned stamp;
        int              free;
        if (r) begin
            mq.delete();
            m_drops = '0;
            m_ovf   = 1'b0;
            m_cycle = 0;
            return;
        end
        stamp   = m_cycle;
        m_cycle = m_cycle + 1;
        if (c) begin
            mq.delete();
            m_drops = '0;
            m_ovf   = 1'b0;
            return;
        end
        if (en) begin
            if (v[0]) reqs.push_back(r0);
            if (v[1]) reqs.push_back(r1);
        end
        free = DEPTH_TB - mq.size();
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        foreach (reqs[i]) begin
            if (i < free) begin
                rec = reqs[i];
`ifdef TRACE_CYCLE_STAMP_EN
                rec.cycle = stamp;
`else
                rec.cycle = '0;
`endif
                mq.push_back(rec);
            end else begin
                m_ovf = 1'b1;
                if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
            end
        end
    endfunction

    function automatic trace_rec_t model_head();
        if (mq.size() != 0) return mq[0];
        return '0;
    endfunction

    task automatic drive(input logic r, input logic c, input logic en, input logic [1:0] v,
                         input trace_rec_t r0, input trace_rec_t r1, input logic rdy);
        rst                  = r;
        clear                = c;
        trace_en             = en;
        bus.commit_valid_i   = v;
        bus.commit_rec_i[0]  = r0;
        bus.commit_rec_i[1]  = r1;
        bus.out_ready_i      = rdy;
        @(posedge clk);
        model_step(r, c, en, v, r0, r1, rdy);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 1'b1, 2'b00, '0, '0, rdy);
    endtask

    task automatic drive_sat(input logic c, input logic en, input logic [1:0] v);
        sat_clear                = c;
        sat_en                   = en;
        bus_sat.commit_valid_i   = v;
        bus_sat.commit_rec_i[0]  = mk_rec(64'h600);
        bus_sat.commit_rec_i[1]  = mk_rec(64'h604);
        idle(1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 2'b11, mk_rec(64'h1), mk_rec(64'h2), 1'b1);
        drive(1'b1, 1'b0, 1'b1, 2'b00, '0, '0, 1'b0);
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.out_valid_o); end
        n_checks++;
        if (bus.out_rec_o !== '0) begin n_fail++; $display("[TB] FAIL reset_rec: got %0h expected 0", bus.out_rec_o); end
        n_checks++;
        if (level !== 3'd0 || overflow !== 1'b0 || drop_cnt !== 32'd0) begin
            n_fail++; $display("[TB] FAIL reset_state: level %0d ovf %0b drop %0d expected 0 0 0", level, overflow, drop_cnt);
        end
        idle(1'b0);
    endtask

    task automatic test_single();
        drive(1'b0, 1'b0, 1'b1, 2'b01, mk_rec(64'h8000_0000), mk_rec(64'hDEAD), 1'b1);
        n_checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_rec_o.pc !== 64'h8000_0000) begin
            n_fail++; $display("[TB] FAIL single_head: valid %0b pc %0h expected 1 80000000", bus.out_valid_o, bus.out_rec_o.pc);
        end
        n_checks++;
        if (bus.out_rec_o !== model_head()) begin n_fail++; $display("[TB] FAIL single_rec: got %0h expected %0h", bus.out_rec_o, model_head()); end
        n_checks++;
        if (level !== 3'd1 || drop_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL single_level: level %0d drop %0d expected 1 0", level, drop_cnt); end
        idle(1'b1);
        n_checks++;
        if (level !== 3'd0 || bus.out_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drain: level %0d valid %0b expected 0 0", level, bus.out_valid_o); end
    endtask

    task automatic test_dual_order();
        logic [63:0] pcs [4];
        pcs[0] = 64'h100; pcs[1] = 64'h104; pcs[2] = 64'h108; pcs[3] = 64'h10C;
        drive(1'b0, 1'b0, 1'b1, 2'b11, mk_rec(pcs[0]), mk_rec(pcs[1]), 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b11, mk_rec(pcs[2]), mk_rec(pcs[3]), 1'b0);
        n_checks++;
        if (level !== 3'd4) begin n_fail++; $display("[TB] FAIL dual_level: got %0d expected 4", level); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.out_valid_o !== 1'b1 || bus.out_rec_o.pc !== pcs[i]) begin
                n_fail++; $display("[TB] FAIL dual_order[%0d]: valid %0b pc %0h expected 1 %0h", i, bus.out_valid_o, bus.out_rec_o.pc, pcs[i]);
            end
            n_checks++;
            if (bus.out_rec_o !== model_head()) begin n_fail++; $display("[TB] FAIL dual_rec[%0d]: got %0h expected %0h", i, bus.out_rec_o, model_head()); end
            idle(1'b1);
        end
        n_checks++;
        if (level !== 3'd0) begin n_fail++; $display("[TB] FAIL dual_empty: got %0d expected 0", level); end
    endtask

    task automatic test_full_drop();
        drive(1'b0, 1'b0, 1'b1, 2'b11, mk_rec(64'h10), mk_rec(64'h14), 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b11, mk_rec(64'h18), mk_rec(64'h1C), 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b11, mk_rec(64'h200), mk_rec(64'h204), 1'b1);
        n_checks++;
        if (drop_cnt !== 32'd2 || overflow !== 1'b1 || level !== 3'd3) begin
            n_fail++; $display("[TB] FAIL full_drop: drop %0d ovf %0b level %0d expected 2 1 3", drop_cnt, overflow, level);
        end
        n_checks++;
        if (bus.out_rec_o.pc !== 64'h14) begin n_fail++; $display("[TB] FAIL full_head: got %0h expected 14", bus.out_rec_o.pc); end
    endtask

    task automatic test_partial_drop();
        drive(1'b0, 1'b0, 1'b1, 2'b11, mk_rec(64'h300), mk_rec(64'h304), 1'b0);
        n_checks++;
        if (drop_cnt !== 32'd3 || level !== 3'd4) begin n_fail++; $display("[TB] FAIL partial_drop: drop %0d level %0d expected 3 4", drop_cnt, level); end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                n_checks++;
                if (bus.out_rec_o.pc !== 64'h300) begin n_fail++; $display("[TB] FAIL partial_last: got %0h expected 300", bus.out_rec_o.pc); end
            end
            n_checks++;
            if (bus.out_rec_o !== model_head()) begin n_fail++; $display("[TB] FAIL partial_rec[%0d]: got %0h expected %0h", i, bus.out_rec_o, model_head()); end
            idle(1'b1);
        end
    endtask

    task automatic test_port1_clear();
        drive(1'b0, 1'b0, 1'b1, 2'b10, mk_rec(64'hBAD), mk_rec(64'h400), 1'b0);
        n_checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_rec_o.pc !== 64'h400 || level !== 3'd1) begin
            n_fail++; $display("[TB] FAIL port1_head: valid %0b pc %0h level %0d expected 1 400 1", bus.out_valid_o, bus.out_rec_o.pc, level);
        end
        drive(1'b0, 1'b1, 1'b1, 2'b11, mk_rec(64'h410), mk_rec(64'h414), 1'b1);
        n_checks++;
        if (level !== 3'd0 || drop_cnt !== 32'd0 || overflow !== 1'b0 || bus.out_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL clear_state: level %0d drop %0d ovf %0b valid %0b expected 0 0 0 0", level, drop_cnt, overflow, bus.out_valid_o);
        end
    endtask

    task automatic test_trace_en();
        drive(1'b0, 1'b0, 1'b1, 2'b11, mk_rec(64'h20), mk_rec(64'h24), 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b11, mk_rec(64'h28), mk_rec(64'h2C), 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 2'b11, mk_rec(64'h30), mk_rec(64'h34), 1'b0);
        n_checks++;
        if (level !== 3'd4 || drop_cnt !== 32'd0 || overflow !== 1'b0) begin
            n_fail++; $display("[TB] FAIL en_off_full: level %0d drop %0d ovf %0b expected 4 0 0", level, drop_cnt, overflow);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 2'b11, mk_rec(64'h40), mk_rec(64'h44), 1'b1);
        n_checks++;
        if (level !== 3'd0 || drop_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL en_off_drain: level %0d drop %0d expected 0 0", level, drop_cnt); end
    endtask

    task automatic test_saturate();
        drive_sat(1'b1, 1'b1, 2'b11);
        drive_sat(1'b0, 1'b1, 2'b11);
        drive_sat(1'b0, 1'b1, 2'b11);
        drive_sat(1'b0, 1'b1, 2'b11);
        n_checks++;
        if (sat_drop !== 2'd2 || sat_ovf !== 1'b1 || sat_level !== 3'd4) begin
            n_fail++; $display("[TB] FAIL sat_preload: drop %0d ovf %0b level %0d expected 2 1 4", sat_drop, sat_ovf, sat_level);
        end
        drive_sat(1'b0, 1'b1, 2'b11);
        n_checks++;
        if (sat_drop !== 2'd3) begin n_fail++; $display("[TB] FAIL sat_limit: got %0d expected 3", sat_drop); end
        drive_sat(1'b0, 1'b1, 2'b01);
        n_checks++;
        if (sat_drop !== 2'd3 || sat_level !== 3'd4) begin n_fail++; $display("[TB] FAIL sat_hold: drop %0d level %0d expected 3 4", sat_drop, sat_level); end
        drive_sat(1'b1, 1'b0, 2'b00);
        n_checks++;
        if (sat_drop !== 2'd0 || sat_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_clear: drop %0d ovf %0b expected 0 0", sat_drop, sat_ovf); end
        drive_sat(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_reset_midstream();
        drive(1'b0, 1'b0, 1'b1, 2'b11, mk_rec(64'h50), mk_rec(64'h54), 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2'b11, mk_rec(64'h58), mk_rec(64'h5C), 1'b1);
        n_checks++;
        if (bus.out_valid_o !== 1'b0 || level !== 3'd0) begin
            n_fail++; $display("[TB] FAIL mid_reset: valid %0b level %0d expected 0 0", bus.out_valid_o, level);
        end
        idle(1'b0);
    endtask

    task automatic test_cycle_stamp();
        logic [63:0] exp_stamp;
`ifdef TRACE_CYCLE_STAMP_EN
        exp_stamp = 64'd10;
`else
        exp_stamp = 64'd0;
`endif
        drive(1'b1, 1'b0, 1'b1, 2'b00, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b11, mk_rec(64'h500), mk_rec(64'h504), 1'b0);
        n_checks++;
        if (bus.out_rec_o.pc !== 64'h500 || bus.out_rec_o.cycle !== exp_stamp) begin
            n_fail++; $display("[TB] FAIL stamp_first: pc %0h cycle %0d expected 500 %0d", bus.out_rec_o.pc, bus.out_rec_o.cycle, exp_stamp);
        end
        idle(1'b1);
        n_checks++;
        if (bus.out_rec_o.pc !== 64'h504 || bus.out_rec_o.cycle !== exp_stamp) begin
            n_fail++; $display("[TB] FAIL stamp_second: pc %0h cycle %0d expected 504 %0d", bus.out_rec_o.pc, bus.out_rec_o.cycle, exp_stamp);
        end
        n_checks++;
        if (bus.out_rec_o !== model_head()) begin n_fail++; $display("[TB] FAIL stamp_rec: got %0h expected %0h", bus.out_rec_o, model_head()); end
        idle(1'b1);
    endtask

    task automatic test_random();
        logic       r, c, en, rdy;
        logic [1:0] v;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 63) == 0);
            en  = ($urandom_range(0, 7) != 0);
            v   = 2'($urandom_range(0, 3));
            rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(r, c, en, v, mk_rec({32'h0, $urandom}), mk_rec({32'h1, $urandom}), rdy);
            n_checks++;
            if (bus.out_valid_o !== (mq.size() != 0) || level !== 3'(mq.size())) begin
                n_fail++; $display("[TB] FAIL rand_level[%0d]: valid %0b level %0d expected %0b %0d", i, bus.out_valid_o, level, mq.size() != 0, mq.size());
            end
            n_checks++;
            if (bus.out_rec_o !== model_head()) begin
                n_fail++; $display("[TB] FAIL rand_rec[%0d]: got %0h expected %0h", i, bus.out_rec_o, model_head());
            end
            n_checks++;
            if (drop_cnt !== m_drops || overflow !== m_ovf) begin
                n_fail++; $display("[TB] FAIL rand_drop[%0d]: drop %0d ovf %0b expected %0d %0b", i, drop_cnt, overflow, m_drops, m_ovf);
            end
        end
    endtask

    initial begin
        rst                     = 1'b1;
        clear                   = 1'b0;
        trace_en                = 1'b0;
        bus.commit_valid_i      = 2'b00;
        bus.commit_rec_i        = '0;
        bus.out_ready_i         = 1'b0;
        sat_en                  = 1'b0;
        sat_clear               = 1'b0;
        bus_sat.commit_valid_i  = 2'b00;
        bus_sat.commit_rec_i    = '0;
        bus_sat.out_ready_i     = 1'b0;
        mq.delete();
        m_drops = '0;
        m_ovf   = 1'b0;
        m_cycle = 0;

        test_reset();
        test_single();
        test_dual_order();
        test_full_drop();
        test_partial_drop();
        test_port1_clear();
        test_trace_en();
        test_saturate();
        test_reset_midstream();
        test_cycle_stamp();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
